// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable clock divider.
// The divisor N and high time H load into pending registers. The pending
// values take effect only at a period boundary, so the divided clock never
// glitches. When enable drops, the current period runs to completion before
// the block idles, so there is no runt pulse.
// Optional build macro CLKDIV_PERIOD_CNT_EN adds a 16-bit count of output
// rising edges on port period_cnt_o.
module clk_div_prog #(
  parameter int WIDTH        = 17,
  parameter int DEFAULT_DIV  = 100000,
  parameter int DEFAULT_DUTY = 0
) (
  input  logic             Clock_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] div_i,
  input  logic [WIDTH-1:0] duty_i,
  input  logic             load_i,
  output logic             Clock_o,
  output logic             tick_o,
  output logic             load_ack_o,
  output logic             active_o
`ifdef CLKDIV_PERIOD_CNT_EN
  ,
  output logic [15:0]      period_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO      = WIDTH'(2);
  localparam logic [WIDTH-1:0] DIV_RST  = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DUTY_RST = WIDTH'(DEFAULT_DUTY);

  // A divisor below 2 cannot hold both a high and a low phase, so clamp it up.
  function automatic logic [WIDTH-1:0] eff_div(input logic [WIDTH-1:0] n);
    return (n < TWO) ? TWO : n;
  endfunction

  // A zero or out-of-range high time falls back to half the period (50 %).
  function automatic logic [WIDTH-1:0] eff_high(input logic [WIDTH-1:0] n_e,
                                                input logic [WIDTH-1:0] h);
    if ((h == '0) || (h >= n_e))
      return n_e >> 1;
    else
      return h;
  endfunction

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div_act;
  logic [WIDTH-1:0] duty_act;
  logic [WIDTH-1:0] div_pend;
  logic [WIDTH-1:0] duty_pend;
  logic             pend;
  logic             clk_q;
  logic             tick_q;
  logic             ack_q;

  logic [WIDTH-1:0] n_eff;
  logic [WIDTH-1:0] h_eff;
  logic [WIDTH-1:0] cnt_inc;
  logic             wrap;
  logic             apply;
  logic             tick_set;

  // Effective period/high time and the boundary events derived from them.
  always_comb begin
    n_eff    = eff_div(div_act);
    h_eff    = eff_high(n_eff, duty_act);
    cnt_inc  = cnt + ONE;
    wrap     = (cnt == (n_eff - ONE));
    // Pending values swap in at a period boundary, or right away while idle.
    apply    = pend && ((state == S_IDLE) || wrap);
    // A rising edge is produced at start and at every wrap except the final
    // wrap of a drain that ends in idle.
    tick_set = ((state == S_IDLE) && enable_i) ||
               ((state == S_RUN) && wrap) ||
               ((state == S_DRAIN) && wrap && enable_i);
  end

  // Divider FSM: counter, registered outputs and divisor/duty bookkeeping.
  always_ff @(posedge Clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state     <= S_IDLE;
      cnt       <= '0;
      div_act   <= DIV_RST;
      duty_act  <= DUTY_RST;
      div_pend  <= DIV_RST;
      duty_pend <= DUTY_RST;
      pend      <= 1'b0;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      tick_q <= tick_set;
      ack_q  <= apply;

      // A load on the same edge as an apply refills pending for the next boundary.
      if (load_i) begin
        div_pend  <= div_i;
        duty_pend <= duty_i;
        pend      <= 1'b1;
      end else if (apply) begin
        pend <= 1'b0;
      end

      if (apply) begin
        div_act  <= div_pend;
        duty_act <= duty_pend;
      end

      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (enable_i) begin
            state <= S_RUN;
            clk_q <= 1'b1;
          end else begin
            clk_q <= 1'b0;
          end
        end
        S_RUN, S_DRAIN: begin
          if ((state == S_DRAIN) && wrap && !enable_i) begin
            state <= S_IDLE;
            cnt   <= '0;
            clk_q <= 1'b0;
          end else begin
            state <= enable_i ? S_RUN : S_DRAIN;
            if (wrap) begin
              cnt   <= '0;
              clk_q <= 1'b1;
            end else begin
              cnt   <= cnt_inc;
              clk_q <= (cnt_inc < h_eff);
            end
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          clk_q <= 1'b0;
        end
      endcase
    end
  end

  assign Clock_o    = clk_q;
  assign tick_o     = tick_q;
  assign load_ack_o = ack_q;
  assign active_o   = (state != S_IDLE);

`ifdef CLKDIV_PERIOD_CNT_EN
  logic [15:0] period_cnt;

  // Count output rising edges; updates on the same edge that raises tick_o.
  always_ff @(posedge Clock_i or negedge reset_i) begin
    if (!reset_i)
      period_cnt <= '0;
    else if (tick_set)
      period_cnt <= period_cnt + 16'd1;
  end

  assign period_cnt_o = period_cnt;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed testbench for clk_div_prog, built with DEFAULT_DIV=10 and DEFAULT_DUTY=0.
// Observed vector per cycle: {Clock_o, tick_o, load_ack_o, active_o}.
module tb_clk_div_prog;

  localparam int W = 17;

  logic         clk = 1'b0;
  logic         reset_i;
  logic         enable_i;
  logic         load_i;
  logic [W-1:0] div_i;
  logic [W-1:0] duty_i;
  logic         clk_o;
  logic         tick_o;
  logic         ack_o;
  logic         active_o;
`ifdef CLKDIV_PERIOD_CNT_EN
  logic [15:0]  pcnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  clk_div_prog #(
    .WIDTH       (W),
    .DEFAULT_DIV (10),
    .DEFAULT_DUTY(0)
  ) dut (
    .Clock_i     (clk),
    .reset_i     (reset_i),
    .enable_i    (enable_i),
    .div_i       (div_i),
    .duty_i      (duty_i),
    .load_i      (load_i),
    .Clock_o     (clk_o),
    .tick_o      (tick_o),
    .load_ack_o  (ack_o),
    .active_o    (active_o)
`ifdef CLKDIV_PERIOD_CNT_EN
    ,
    .period_cnt_o(pcnt)
`endif
  );

  // Advance one edge and sample just after it.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reset pulse, one idle edge, then the start edge (cnt=0, Clock_o high).
  task automatic do_reset_start;
    reset_i  = 1'b0;
    enable_i = 1'b0;
    load_i   = 1'b0;
    div_i    = '0;
    duty_i   = '0;
    #2;
    reset_i = 1'b1;
    step;
    enable_i = 1'b1;
    step;
  endtask

  task automatic test_reset;
    logic [3:0] obs;
    logic [3:0] exp;
    reset_i  = 1'b0;
    enable_i = 1'b0;
    load_i   = 1'b0;
    div_i    = '0;
    duty_i   = '0;
    repeat (3) step;
    obs = {clk_o, tick_o, ack_o, active_o};
    total++;
    if (obs !== 4'b0000) begin
      bad++;
      $display("FAIL reset_state got=%b want=0000", obs);
    end
`ifdef CLKDIV_PERIOD_CNT_EN
    total++;
    if (pcnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_pcnt got=%0d want=0", pcnt);
    end
`endif
    reset_i = 1'b1;
    step;
    obs = {clk_o, tick_o, ack_o, active_o};
    total++;
    if (obs !== 4'b0000) begin
      bad++;
      $display("FAIL idle_after_reset got=%b want=0000", obs);
    end
    // Load in IDLE: captured on one edge, applied (ack) on the next.
    load_i = 1'b1; div_i = 4; duty_i = 0;
    step;
    load_i = 1'b0;
    exp = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) exp = 4'b0010; else exp = 4'b0000;
      obs = {clk_o, tick_o, ack_o, active_o};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL idle_load k=%0d got=%b want=%b", k, obs, exp);
      end
      step;
    end
    // Start with N=4, H=2.
    enable_i = 1'b1;
    step;
    obs = {clk_o, tick_o, ack_o, active_o};
    total++;
    if (obs !== 4'b1101) begin
      bad++;
      $display("FAIL idle_start got=%b want=1101", obs);
    end
    for (int j = 1; j <= 8; j++) begin
      step;
      exp = {(j % 4) < 2, (j % 4) == 0, 1'b0, 1'b1};
      obs = {clk_o, tick_o, ack_o, active_o};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL idle_loaded_div4 j=%0d got=%b want=%b", j, obs, exp);
      end
    end
  endtask

  task automatic test_basic;
    logic [3:0] obs;
    logic [3:0] exp;
    reset_i  = 1'b0;
    enable_i = 1'b0;
    load_i   = 1'b0;
    #2;
    reset_i = 1'b1;
    step;
    obs = {clk_o, tick_o, ack_o, active_o};
    total++;
    if (obs !== 4'b0000) begin
      bad++;
      $display("FAIL basic_pre_enable got=%b want=0000", obs);
    end
    enable_i = 1'b1;
    step;
    obs = {clk_o, tick_o, ack_o, active_o};
    total++;
    if (obs !== 4'b1101) begin
      bad++;
      $display("FAIL basic_start got=%b want=1101", obs);
    end
    for (int j = 1; j <= 29; j++) begin
      step;
      exp = {(j % 10) < 5, (j % 10) == 0, 1'b0, 1'b1};
      obs = {clk_o, tick_o, ack_o, active_o};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL basic_div10 j=%0d got=%b want=%b", j, obs, exp);
      end
    end
  endtask

  task automatic test_load;
    logic [3:0] obs;
    logic [3:0] exp;
    do_reset_start;
    repeat (3) step;
    load_i = 1'b1; div_i = 4; duty_i = 1;
    step;
    load_i = 1'b0;
    for (int j = 4; j <= 9; j++) begin
      if (j > 4) step;
      exp = {j < 5, 1'b0, 1'b0, 1'b1};
      obs = {clk_o, tick_o, ack_o, active_o};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL load_before_wrap cnt=%0d got=%b want=%b", j, obs, exp);
      end
    end
    step;
    obs = {clk_o, tick_o, ack_o, active_o};
    total++;
    if (obs !== 4'b1111) begin
      bad++;
      $display("FAIL load_wrap_ack got=%b want=1111", obs);
    end
    for (int j = 1; j <= 8; j++) begin
      step;
      exp = {(j % 4) < 1, (j % 4) == 0, 1'b0, 1'b1};
      obs = {clk_o, tick_o, ack_o, active_o};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL load_div4_duty1 j=%0d got=%b want=%b", j, obs, exp);
      end
    end
  endtask

  task automatic test_min_div;
    logic [3:0] obs;
    logic [3:0] exp;
    do_reset_start;
    load_i = 1'b1; div_i = 1; duty_i = 0;
    step;
    load_i = 1'b0;
    for (int j = 2; j <= 9; j++) begin
      step;
      exp = {j < 5, 1'b0, 1'b0, 1'b1};
      obs = {clk_o, tick_o, ack_o, active_o};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL min_before_wrap cnt=%0d got=%b want=%b", j, obs, exp);
      end
    end
    step;
    obs = {clk_o, tick_o, ack_o, active_o};
    total++;
    if (obs !== 4'b1111) begin
      bad++;
      $display("FAIL min_wrap_ack got=%b want=1111", obs);
    end
    for (int j = 1; j <= 6; j++) begin
      step;
      exp = {(j % 2) == 0, (j % 2) == 0, 1'b0, 1'b1};
      obs = {clk_o, tick_o, ack_o, active_o};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL min_div2 j=%0d got=%b want=%b", j, obs, exp);
      end
    end
    // div 6 with out-of-range duty 9 -> high time 3.
    load_i = 1'b1; div_i = 6; duty_i = 9;
    step;
    load_i = 1'b0;
    obs = {clk_o, tick_o, ack_o, active_o};
    total++;
    if (obs !== 4'b0001) begin
      bad++;
      $display("FAIL min_reload_low got=%b want=0001", obs);
    end
    step;
    obs = {clk_o, tick_o, ack_o, active_o};
    total++;
    if (obs !== 4'b1111) begin
      bad++;
      $display("FAIL min_reload_ack got=%b want=1111", obs);
    end
    for (int j = 1; j <= 11; j++) begin
      step;
      exp = {(j % 6) < 3, (j % 6) == 0, 1'b0, 1'b1};
      obs = {clk_o, tick_o, ack_o, active_o};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL div6_duty9 j=%0d got=%b want=%b", j, obs, exp);
      end
    end
  endtask

  task automatic test_drain;
    logic [3:0] obs;
    logic [3:0] exp;
    do_reset_start;
    repeat (2) step;
    enable_i = 1'b0;
    for (int j = 3; j <= 9; j++) begin
      step;
      exp = {j < 5, 1'b0, 1'b0, 1'b1};
      obs = {clk_o, tick_o, ack_o, active_o};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL drain_cnt cnt=%0d got=%b want=%b", j, obs, exp);
      end
    end
    for (int k = 0; k < 4; k++) begin
      step;
      obs = {clk_o, tick_o, ack_o, active_o};
      total++;
      if (obs !== 4'b0000) begin
        bad++;
        $display("FAIL drain_idle k=%0d got=%b want=0000", k, obs);
      end
    end
    // Restart, drop enable, then re-enable during the drain at cnt=7.
    enable_i = 1'b1;
    step;
    obs = {clk_o, tick_o, ack_o, active_o};
    total++;
    if (obs !== 4'b1101) begin
      bad++;
      $display("FAIL drain_restart got=%b want=1101", obs);
    end
    enable_i = 1'b0;
    for (int j = 1; j <= 9; j++) begin
      step;
      if (j == 7) enable_i = 1'b1;
      exp = {j < 5, 1'b0, 1'b0, 1'b1};
      obs = {clk_o, tick_o, ack_o, active_o};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL drain_reenable cnt=%0d got=%b want=%b", j, obs, exp);
      end
    end
    step;
    obs = {clk_o, tick_o, ack_o, active_o};
    total++;
    if (obs !== 4'b1101) begin
      bad++;
      $display("FAIL drain_reenable_wrap got=%b want=1101", obs);
    end
    step;
    obs = {clk_o, tick_o, ack_o, active_o};
    total++;
    if (obs !== 4'b1001) begin
      bad++;
      $display("FAIL drain_after_wrap got=%b want=1001", obs);
    end
  endtask

  task automatic test_double_load;
    logic [3:0] obs;
    logic [3:0] exp;
    do_reset_start;
    step;
    load_i = 1'b1; div_i = 8; duty_i = 0;
    step;
    load_i = 1'b0;
    step;
    load_i = 1'b1; div_i = 6; duty_i = 0;
    step;
    load_i = 1'b0;
    for (int j = 4; j <= 9; j++) begin
      if (j > 4) step;
      exp = {j < 5, 1'b0, 1'b0, 1'b1};
      obs = {clk_o, tick_o, ack_o, active_o};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL dbl_before_wrap cnt=%0d got=%b want=%b", j, obs, exp);
      end
    end
    step;
    obs = {clk_o, tick_o, ack_o, active_o};
    total++;
    if (obs !== 4'b1111) begin
      bad++;
      $display("FAIL dbl_wrap_ack got=%b want=1111", obs);
    end
    for (int j = 1; j <= 12; j++) begin
      step;
      exp = {(j % 6) < 3, (j % 6) == 0, 1'b0, 1'b1};
      obs = {clk_o, tick_o, ack_o, active_o};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL dbl_div6 j=%0d got=%b want=%b", j, obs, exp);
      end
    end
  endtask

  task automatic test_async_reset;
    logic [3:0] obs;
    logic [3:0] exp;
    do_reset_start;
    step;
    obs = {clk_o, tick_o, ack_o, active_o};
    total++;
    if (obs !== 4'b1001) begin
      bad++;
      $display("FAIL areset_pre got=%b want=1001", obs);
    end
    #2;
    reset_i = 1'b0;
    #1;
    obs = {clk_o, tick_o, ack_o, active_o};
    total++;
    if (obs !== 4'b0000) begin
      bad++;
      $display("FAIL areset_immediate got=%b want=0000", obs);
    end
`ifdef CLKDIV_PERIOD_CNT_EN
    total++;
    if (pcnt !== 16'd0) begin
      bad++;
      $display("FAIL areset_pcnt got=%0d want=0", pcnt);
    end
`endif
    #1;
    reset_i = 1'b1;
    step;
    obs = {clk_o, tick_o, ack_o, active_o};
    total++;
    if (obs !== 4'b1101) begin
      bad++;
      $display("FAIL areset_restart got=%b want=1101", obs);
    end
    for (int j = 1; j <= 20; j++) begin
      step;
      exp = {(j % 10) < 5, (j % 10) == 0, 1'b0, 1'b1};
      obs = {clk_o, tick_o, ack_o, active_o};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL areset_run j=%0d got=%b want=%b", j, obs, exp);
      end
    end
`ifdef CLKDIV_PERIOD_CNT_EN
    total++;
    if (pcnt !== 16'd3) begin
      bad++;
      $display("FAIL pcnt_three got=%0d want=3", pcnt);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_basic;
    test_load;
    test_min_div;
    test_drain;
    test_double_load;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
